// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame defaults shared by the UART receiver and transmitter
package uart_pkg;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;
    localparam int DBITS_DEF   = 8;
    localparam int SB_TICK_DEF = 16;
endpackage

// File: rtl/rx_synchronizer.sv
// rx_synchronizer: 2-FF synchronizer for the serial line, resets to idle-high
module rx_synchronizer (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    // two-stage shift; both stages start at 1 so reset never looks like a start edge
    always_ff @(posedge clk_100MHz or posedge reset)
        if (reset) {q, meta} <= 2'b11;
        else       {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver, mid-bit sampling, byte + ready/framing pulses
module uart_receiver import uart_pkg::*; #(
    parameter int DBITS   = DBITS_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx,
    input  logic             sample_tick,
    output logic [DBITS-1:0] data_out,
    output logic             data_ready,
    output logic             framing_error
);
    logic             rx_s, rx_s_d;
    logic [1:0]       state, state_n;
    logic [4:0]       s_cnt, s_n;
    logic [2:0]       n_cnt, n_n;
    logic [DBITS-1:0] shift, shift_n, dout_n;
    logic             rdy_n, fe_n;

    rx_synchronizer u_sync (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .d         (rx),
        .q         (rx_s)
    );

    // next-state: edge detect in IDLE runs every clock, everything else only on ticks
    always_comb begin
        state_n = state;
        s_n     = s_cnt;
        n_n     = n_cnt;
        shift_n = shift;
        dout_n  = data_out;
        rdy_n   = 1'b0;
        fe_n    = 1'b0;
        case (state)
            IDLE:
                if (rx_s_d && !rx_s) begin
                    s_n     = '0;
                    state_n = START;
                end
            START:
                if (sample_tick) begin
                    if (s_cnt == 5'd7) begin
                        if (!rx_s) begin
                            s_n     = '0;
                            n_n     = '0;
                            state_n = DATA;
                        end else state_n = IDLE;
                    end else s_n = s_cnt + 5'd1;
                end
            DATA:
                if (sample_tick) begin
                    if (s_cnt == 5'd15) begin
                        s_n     = '0;
                        shift_n = {rx_s, shift[DBITS-1:1]};
                        if (n_cnt == 3'(DBITS - 1)) state_n = STOP;
                        else n_n = n_cnt + 3'd1;
                    end else s_n = s_cnt + 5'd1;
                end
            default:
                if (sample_tick) begin
                    if (s_cnt == 5'(SB_TICK - 1)) begin
                        dout_n  = shift;
                        rdy_n   = 1'b1;
                        fe_n    = !rx_s;
                        state_n = IDLE;
                    end else s_n = s_cnt + 5'd1;
                end
        endcase
    end

    // all receiver state in one register bank; async reset aborts any frame silently
    always_ff @(posedge clk_100MHz or posedge reset)
        if (reset) begin
            state         <= IDLE;
            s_cnt         <= '0;
            n_cnt         <= '0;
            shift         <= '0;
            data_out      <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            rx_s_d        <= 1'b1;
        end else begin
            state         <= state_n;
            s_cnt         <= s_n;
            n_cnt         <= n_n;
            shift         <= shift_n;
            data_out      <= dout_n;
            data_ready    <= rdy_n;
            framing_error <= fe_n;
            rx_s_d        <= rx_s;
        end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against a queue-based expected-byte model
module tb_uart_receiver;
    localparam int TDIV = 4;
    localparam int BIT  = 16 * TDIV;

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       sample_tick;
    logic [7:0] data_out;
    logic       data_ready, framing_error;
    logic [1:0] tcnt = '0;
    logic       tick_all = 1'b0;

    int         n_chk = 0, n_fail = 0, pulses = 0;
    logic [7:0] cap_data = '0;
    logic       cap_fe = 1'b0;
    logic [8:0] exp_q[$];
    logic [7:0] model_last = '0;

    uart_receiver #(.DBITS(8), .SB_TICK(16)) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .rx           (rx),
        .sample_tick  (sample_tick),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .framing_error(framing_error)
    );

    always #5 clk_100MHz = ~clk_100MHz;
    always @(posedge clk_100MHz) tcnt <= tcnt + 2'd1;
    assign sample_tick = tick_all || (tcnt == 2'(TDIV - 1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_100MHz) begin
        logic [8:0] e;
        if (reset) begin
            model_last = '0;
            chk("reset_outputs", {data_out, data_ready, framing_error}, 10'h0);
        end else if (data_ready) begin
            pulses++;
            cap_data = data_out;
            cap_fe   = framing_error;
            if (exp_q.size() == 0) chk("unexpected_pulse", {data_out, framing_error}, 9'h1ff);
            else begin
                e = exp_q.pop_front();
                model_last = e[8:1];
                chk("pulse_data", data_out, e[8:1]);
                chk("pulse_fe", framing_error, e[0]);
            end
        end else begin
            chk("hold_data", data_out, model_last);
            chk("fe_idle", framing_error, 1'b0);
        end
    end

    task automatic send(input logic [7:0] d, input logic stop, input int bitclk, input int maxclk);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int c = 0; c < 10 * bitclk && c < maxclk; c++) begin
            @(negedge clk_100MHz);
            rx = f[c / bitclk];
        end
    endtask

    task automatic idle(input int clks);
        rx = 1'b1;
        repeat (clks) @(negedge clk_100MHz);
    endtask

    initial begin
        repeat (4) @(negedge clk_100MHz);
        #1;
        chk("init_data", data_out, 8'h00);
        chk("init_ready", data_ready, 1'b0);
        chk("init_fe", framing_error, 1'b0);
        @(negedge clk_100MHz);
        reset = 1'b0;
        idle(2 * BIT);

        // T1: two good frames
        exp_q.push_back({8'h55, 1'b0});
        send(8'h55, 1'b1, BIT, 10 * BIT);
        exp_q.push_back({8'hA3, 1'b0});
        send(8'hA3, 1'b1, BIT, 10 * BIT);
        idle(2 * BIT);
        chk("t1_pulses", pulses, 2);
        chk("t1_last", data_out, 8'hA3);

        // T2: short low glitch must be rejected at mid-start
        rx = 1'b0;
        repeat (8) @(negedge clk_100MHz);
        idle(3 * BIT);
        chk("t2_pulses", pulses, 2);
        chk("t2_hold", data_out, 8'hA3);

        // T3: bad stop bit
        exp_q.push_back({8'h7E, 1'b1});
        send(8'h7E, 1'b0, BIT, 10 * BIT);
        idle(2 * BIT);
        chk("t3_pulses", pulses, 3);
        chk("t3_data", cap_data, 8'h7E);
        chk("t3_fe", cap_fe, 1'b1);

        // T5: reset in the middle of data bit 4, then a clean frame
        send(8'hC6, 1'b1, BIT, 5 * BIT + BIT / 2);
        #1 reset = 1'b1;
        #1 chk("t5_async_clear", data_out, 8'h00);
        rx = 1'b1;
        repeat (5) @(negedge clk_100MHz);
        reset = 1'b0;
        idle(2 * BIT);
        chk("t5_no_pulse", pulses, 3);
        exp_q.push_back({8'h3C, 1'b0});
        send(8'h3C, 1'b1, BIT, 10 * BIT);
        idle(2 * BIT);
        chk("t5_data", data_out, 8'h3C);

        // T4: 30-bit break gives exactly one framing error
        exp_q.push_back({8'h00, 1'b1});
        rx = 1'b0;
        repeat (30 * BIT) @(negedge clk_100MHz);
        chk("t4_pulses", pulses, 5);
        chk("t4_data", cap_data, 8'h00);
        chk("t4_fe", cap_fe, 1'b1);
        idle(3 * BIT);
        chk("t4_after", pulses, 5);

        // T6: back-to-back frames with +/-3% baud skew
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({8'(i), 1'b0});
            send(8'(i), 1'b1, (i % 2) ? BIT + 2 : BIT - 2, 10 * BIT + 20);
        end
        idle(2 * BIT);
        chk("t6_pulses", pulses, 15);
        chk("t6_last", data_out, 8'h09);

        // sample_tick held high: every clock is a tick
        tick_all = 1'b1;
        exp_q.push_back({8'hA5, 1'b0});
        send(8'hA5, 1'b1, 16, 160);
        idle(64);
        tick_all = 1'b0;
        chk("tick_all_data", data_out, 8'hA5);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk_100MHz);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
